// File: rtl/circle_points_stream.sv
// Midpoint circle generator: streams the 8 symmetric points of each step around a latched centre.
// Latency: first point one cycle after an accepted _start; one STEP bubble cycle per group.
// Backpressure: a point is held on _out0/_out1 until _valid && _ready; disabled octants cost no cycles.
module circle_points_stream #(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset_n,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] s_x,
    input  logic signed [WIDTH-1:0] s_y,
    input  logic signed [WIDTH-1:0] height,
    input  logic [7:0]              octant_mask,
    output logic signed [WIDTH-1:0] _out0,
    output logic signed [WIDTH-1:0] _out1,
    output logic                    _valid,
    input  logic                    _ready,
    output logic                    _busy,
    output logic                    _done
);

    // Decision variable carries 4 extra bits so 4*(x-y)+10 cannot overflow it.
    localparam int DW = WIDTH + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [DW-1:0]    d_q, d_d;
    logic signed [WIDTH-1:0] sx_q, sx_d;
    logic signed [WIDTH-1:0] sy_q, sy_d;
    logic [7:0]              mask_q, mask_d;
    logic [2:0]              p_q, p_d;

    logic [3:0]              start_sel;
    logic [3:0]              first_sel;
    logic [3:0]              next_sel;
    logic signed [DW-1:0]    he, xe, ye;
    logic signed [WIDTH-1:0] pa, pb, px, py;

    // Returns {found, index} of the lowest enabled octant at or above 'from'.
    function automatic logic [3:0] first_enabled(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    assign he        = {{4{height[WIDTH-1]}}, height};
    assign start_sel = first_enabled(octant_mask, 4'd0);
    assign first_sel = first_enabled(mask_q, 4'd0);
    assign next_sel  = first_enabled(mask_q, {1'b0, p_q} + 4'd1);

    // State register and datapath registers.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            mask_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            d_q     <= d_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            mask_q  <= mask_d;
            p_q     <= p_d;
        end
    end

    // Next-state: command accept, octant walk on handshake, and the midpoint step.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        d_d     = d_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        mask_d  = mask_q;
        p_d     = p_q;
        xe      = '0;
        ye      = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (_start) begin
                    sx_d   = s_x;
                    sy_d   = s_y;
                    mask_d = octant_mask;
                    x_d    = '0;
                    y_d    = height;
                    d_d    = DW'(3) - (he <<< 1);
                    p_d    = start_sel[2:0];
                    state_d = start_sel[3] ? S_EMIT : S_STEP;
                end
            end
            S_EMIT: begin
                if (_ready) begin
                    if (next_sel[3]) begin
                        p_d = next_sel[2:0];
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                // Loop test uses the pre-increment coordinates.
                if (!(y_q >= x_q)) begin
                    state_d = S_DONE;
                end else begin
                    x_d = x_q + WIDTH'(1);
                    if (!d_q[DW-1] && (d_q != '0)) begin
                        y_d = y_q - WIDTH'(1);
                    end
                    xe = {{4{x_d[WIDTH-1]}}, x_d};
                    ye = {{4{y_d[WIDTH-1]}}, y_d};
                    if (!d_q[DW-1] && (d_q != '0)) begin
                        d_d = d_q + ((xe - ye) <<< 2) + DW'(10);
                    end else begin
                        d_d = d_q + (xe <<< 2) + DW'(6);
                    end
                    p_d     = first_sel[2:0];
                    state_d = first_sel[3] ? S_EMIT : S_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Point select: bit 2 swaps x/y, bit 1 negates the x offset, bit 0 negates the y offset.
    always_comb begin
        pa = p_q[2] ? y_q : x_q;
        pb = p_q[2] ? x_q : y_q;
        px = p_q[1] ? (sx_q - pa) : (sx_q + pa);
        py = p_q[0] ? (sy_q - pb) : (sy_q + pb);
    end

    assign _valid = (state_q == S_EMIT);
    assign _busy  = (state_q == S_EMIT) || (state_q == S_STEP);
    assign _done  = (state_q == S_DONE);
    assign _out0  = _valid ? px : '0;
    assign _out1  = _valid ? py : '0;

endmodule

// File: tb/tb_circle_points_stream.sv
// Directed bench for circle_points_stream: hand-computed point groups, stall hold, wrap, reset abort.
// Point streams are collected at the falling edge and compared against expected group tables.
// Ready is either held high or driven pseudo-randomly to exercise backpressure.
module tb_circle_points_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic               start = 1'b0;
    logic signed [31:0] sx = '0, sy = '0, h = '0;
    logic [7:0]         mask = '0;
    logic signed [31:0] o0, o1;
    logic               vld, busy, done;
    logic               rdy = 1'b1;

    logic              start8 = 1'b0;
    logic signed [7:0] sx8 = '0, sy8 = '0, h8 = '0;
    logic [7:0]        mask8 = '0;
    logic signed [7:0] o8_0, o8_1;
    logic              vld8, busy8, done8;
    logic              rdy8 = 1'b1;

    int total = 0;
    int bad = 0;

    int qx[$], qy[$];
    int ex[$], ey[$];

    always #5 clk = ~clk;

    circle_points_stream #(.WIDTH(32)) dut (
        ._clock(clk), ._reset_n(rst_n), ._start(start),
        .s_x(sx), .s_y(sy), .height(h), .octant_mask(mask),
        ._out0(o0), ._out1(o1), ._valid(vld), ._ready(rdy),
        ._busy(busy), ._done(done)
    );

    circle_points_stream #(.WIDTH(8)) dut8 (
        ._clock(clk), ._reset_n(rst_n), ._start(start8),
        .s_x(sx8), .s_y(sy8), .height(h8), .octant_mask(mask8),
        ._out0(o8_0), ._out1(o8_1), ._valid(vld8), ._ready(rdy8),
        ._busy(busy8), ._done(done8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Appends the enabled points of one midpoint group in the documented octant order.
    task automatic add_group(input int cx, input int cy, input int x, input int y, input logic [7:0] m);
        int px, py;
        for (int p = 0; p < 8; p++) begin
            case (p)
                0: begin px = cx + x; py = cy + y; end
                1: begin px = cx + x; py = cy - y; end
                2: begin px = cx - x; py = cy + y; end
                3: begin px = cx - x; py = cy - y; end
                4: begin px = cx + y; py = cy + x; end
                5: begin px = cx + y; py = cy - x; end
                6: begin px = cx - y; py = cy + x; end
                default: begin px = cx - y; py = cy - x; end
            endcase
            if (m[p]) begin
                ex.push_back(px);
                ey.push_back(py);
            end
        end
    endtask

    // Height-3 circle groups, hand-derived: (0,3) (1,3) (2,2) (3,1).
    task automatic expect_h3(input logic [7:0] m);
        ex.delete(); ey.delete();
        add_group(0, 0, 0, 3, m);
        add_group(0, 0, 1, 3, m);
        add_group(0, 0, 2, 2, m);
        add_group(0, 0, 3, 1, m);
    endtask

    task automatic cmp_stream(input string tag);
        chk($sformatf("%s_count", tag), 64'(qx.size()), 64'(ex.size()));
        for (int i = 0; i < qx.size() && i < ex.size(); i++) begin
            chk($sformatf("%s_pt%0d", tag, i), {qx[i], qy[i]}, {ex[i], ey[i]});
        end
    endtask

    // Issues one command and collects the point stream; cycle 0 is the _start cycle.
    task automatic run_cmd(input int sx_v, input int sy_v, input int h_v, input logic [7:0] m_v,
                           input int rdy_pct, input int glitch_cyc, output int done_cyc);
        logic        held;
        logic [63:0] held_pt;
        held = 1'b0;
        held_pt = '0;
        done_cyc = -1;
        qx.delete(); qy.delete();
        @(negedge clk);
        sx = sx_v; sy = sy_v; h = h_v; mask = m_v;
        start = 1'b1;
        for (int c = 1; c <= 3000 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = (c == glitch_cyc);
            if (c == glitch_cyc) begin
                sx = 99; sy = -5; h = 7; mask = 8'h0F;
            end
            if (c == 1) begin
                chk("busy_first_cycle", 64'(busy), 64'd1);
                chk("done_dropped", 64'(done), 64'd0);
            end
            if (held) begin
                chk("stall_point_held", {o0, o1}, held_pt);
                chk("stall_valid_held", 64'(vld), 64'd1);
            end
            if (done) begin
                done_cyc = c;
                chk("done_not_busy", 64'(busy), 64'd0);
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
                if (vld && rdy) begin
                    qx.push_back(o0);
                    qy.push_back(o1);
                end
                held = vld && !rdy;
                held_pt = {o0, o1};
            end
        end
        start = 1'b0;
        rdy = 1'b1;
        chk("run_completed", 64'(done_cyc >= 0), 64'd1);
    endtask

    initial begin
        int dc;
        int cnt;
        int q8x[$], q8y[$];

        // Reset state.
        #3;
        chk("rst_out0", 64'(o0), 64'd0);
        chk("rst_out1", 64'(o1), 64'd0);
        chk("rst_valid", 64'(vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_w8_out", {48'd0, o8_0, o8_1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(vld), 64'd0);

        // Height 0: groups (0,0) and (1,-1) around (10,20); 9*2+1 cycles.
        ex.delete(); ey.delete();
        add_group(10, 20, 0, 0, 8'hFF);
        add_group(10, 20, 1, -1, 8'hFF);
        run_cmd(10, 20, 0, 8'hFF, 100, -1, dc);
        cmp_stream("h0");
        chk("h0_done_cycle", 64'(dc), 64'd19);

        // Height 3, all octants: 32 points, 9*4+1 cycles, final x/y/d.
        expect_h3(8'hFF);
        run_cmd(0, 0, 3, 8'hFF, 100, -1, dc);
        cmp_stream("h3");
        chk("h3_done_cycle", 64'(dc), 64'd37);
        chk("h3_final_x", 64'(dut.x_q), 64'd3);
        chk("h3_final_y", 64'(dut.y_q), 64'd1);
        chk("h3_final_d", 64'(dut.d_q), 64'd35);

        // Single octant: (0,3),(1,3),(2,2),(3,1); one emit plus one step per group.
        expect_h3(8'h01);
        run_cmd(0, 0, 3, 8'h01, 100, -1, dc);
        cmp_stream("m01");
        chk("m01_done_cycle", 64'(dc), 64'd9);

        // Empty mask: only step cycles, no points.
        ex.delete(); ey.delete();
        run_cmd(0, 0, 3, 8'h00, 100, -1, dc);
        cmp_stream("m00");
        chk("m00_done_cycle", 64'(dc), 64'd5);

        // Negative height: initial group only, then exit.
        ex.delete(); ey.delete();
        ex.push_back(5); ey.push_back(4);
        run_cmd(5, 5, -1, 8'h01, 100, -1, dc);
        cmp_stream("neg");
        chk("neg_done_cycle", 64'(dc), 64'd3);

        // Backpressure at ~30% ready.
        expect_h3(8'hFF);
        run_cmd(0, 0, 3, 8'hFF, 30, -1, dc);
        cmp_stream("bp30");

        // 8-bit width: 127+2 wraps to -127.
        q8x.delete(); q8y.delete();
        @(negedge clk);
        sx8 = 8'sd127; sy8 = 8'sd0; h8 = 8'sd2; mask8 = 8'h10;
        start8 = 1'b1;
        dc = -1;
        for (int c = 1; c <= 50 && dc < 0; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) dc = c;
            else if (vld8 && rdy8) begin
                q8x.push_back(int'(o8_0));
                q8y.push_back(int'(o8_1));
            end
        end
        chk("w8_count", 64'(q8x.size()), 64'd3);
        chk("w8_done_cycle", 64'(dc), 64'd7);
        if (q8x.size() == 3) begin
            chk("w8_pt0", {q8x[0], q8y[0]}, {-32'sd127, 32'sd0});
            chk("w8_pt1", {q8x[1], q8y[1]}, {-32'sd127, 32'sd1});
            chk("w8_pt2", {q8x[2], q8y[2]}, {-32'sd128, 32'sd2});
        end

        // Abort with reset after 5 points.
        cnt = 0;
        @(negedge clk);
        sx = 0; sy = 0; h = 3; mask = 8'hFF;
        start = 1'b1;
        for (int c = 0; c < 60 && cnt < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (vld && rdy) cnt++;
        end
        chk("abort_points_seen", 64'(cnt), 64'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out0", 64'(o0), 64'd0);
        chk("abort_out1", 64'(o1), 64'd0);
        chk("abort_valid", 64'(vld), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_still_idle", 64'(vld), 64'd0);
        rst_n = 1'b1;

        // Fresh command after abort, with an ignored _start pulse mid-command.
        expect_h3(8'hFF);
        run_cmd(0, 0, 3, 8'hFF, 100, 7, dc);
        cmp_stream("after_rst");
        chk("after_rst_done_cycle", 64'(dc), 64'd37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
